// File: rtl/chunked_adder_if.sv
// -----------------------------------------------------------------------------
// chunked_adder_if
// Handshake and data bundle for chunked_adder.
//
// Operand side  : in_valid/in_ready handshake carrying a, b, cin, sub.
// Result side   : out_valid/out_ready handshake carrying sum, cout, ovf.
//
// Handshake rule (both sides): a transfer happens on the rising clock edge
// where valid and ready are both 1. The producer holds its payload stable
// while valid is high. On this block, ready/valid outputs are decoded from
// state only, so they never depend combinationally on the partner's signal.
//
// Modports:
//   master - the operand producer / result consumer (testbench, datapath)
//   slave  - the chunked_adder itself
// -----------------------------------------------------------------------------
interface chunked_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/chunked_adder.sv
// -----------------------------------------------------------------------------
// chunked_adder
// Multi-cycle WIDTH-bit adder/subtractor that adds CHUNK bits per clock and
// keeps the inter-chunk carry in a register, so the longest combinational
// path is one CHUNK-bit carry chain.
//
// Parameters:
//   WIDTH - operand/result width, must be a multiple of CHUNK
//   CHUNK - bits added per clock (NCHUNK = WIDTH/CHUNK cycles per result)
//
// Ports:
//   clk       - rising-edge clock
//   rst_n     - asynchronous active-low reset
//   bus       - chunked_adder_if.slave (operand and result handshakes)
//   dbg_state - current FSM state (0 IDLE, 1 RUN, 2 DONE)
//
// Optional feature macro: CHUNKED_ADDER_SUB_EN
//   defined   - bus.sub=1 computes a - b - cin (cout=1 means no borrow)
//   undefined - bus.sub is ignored, the block only adds
// -----------------------------------------------------------------------------
module chunked_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    chunked_adder_if.slave  bus,
    output logic [1:0]      dbg_state
);
    // Illegal WIDTH/CHUNK combinations divide by zero here and stop elaboration.
    localparam int CFG_OK = 1 / (((CHUNK > 0) && (CHUNK <= WIDTH) && ((WIDTH % CHUNK) == 0)) ? 1 : 0);
    localparam int NCHUNK = (WIDTH / CHUNK) * CFG_OK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;      // effective b (already inverted for subtract)
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             cout_q;
    logic             ovf_q;
    logic [CW-1:0]    k_q;

    logic [WIDTH-1:0] b_eff;
    logic             c_eff;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_res;
    logic [WIDTH-1:0] sum_nxt;
    logic             msb_cin;

`ifdef CHUNKED_ADDER_SUB_EN
    // a - b - cin == a + ~b + ~cin (mod 2^WIDTH)
    assign b_eff = bus.sub ? ~bus.b : bus.b;
    assign c_eff = bus.cin ^ bus.sub;
`else
    logic unused_sub;
    assign unused_sub = bus.sub;
    assign b_eff      = bus.b;
    assign c_eff      = bus.cin;
`endif

    // Select the active chunk with constant part-selects (a mux per chunk).
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (k_q == CW'(i)) begin
                a_chunk = a_q[i*CHUNK +: CHUNK];
                b_chunk = b_q[i*CHUNK +: CHUNK];
            end
        end
    end

    assign chunk_res = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};

    // Carry into the chunk's top bit, recovered from that bit's sum.
    assign msb_cin = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_res[CHUNK-1];

    always_comb begin
        sum_nxt = sum_q;
        for (int i = 0; i < NCHUNK; i++) begin
            if (k_q == CW'(i)) begin
                sum_nxt[i*CHUNK +: CHUNK] = chunk_res[CHUNK-1:0];
            end
        end
    end

    // Next state and handshake outputs; ready/valid depend on state only.
    always_comb begin
        state_d       = state_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_d = RUN;
            end
            RUN: begin
                if (k_q == LAST) state_d = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q     <= bus.a;
                        b_q     <= b_eff;
                        carry_q <= c_eff;
                        sum_q   <= '0;
                        cout_q  <= 1'b0;
                        ovf_q   <= 1'b0;
                        k_q     <= '0;
                    end
                end
                RUN: begin
                    sum_q   <= sum_nxt;
                    carry_q <= chunk_res[CHUNK];
                    k_q     <= k_q + CW'(1);
                    if (k_q == LAST) begin
                        cout_q <= chunk_res[CHUNK];
                        ovf_q  <= msb_cin ^ chunk_res[CHUNK];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_chunked_adder.sv
// -----------------------------------------------------------------------------
// tb_chunked_adder
// Self-checking bench for chunked_adder (WIDTH=16, CHUNK=4). Expected results
// come from plain integer arithmetic on the operands, kept in exp_q.
// Works with CHUNKED_ADDER_SUB_EN defined or undefined.
// -----------------------------------------------------------------------------
module tb_chunked_adder;
    localparam int WIDTH  = 16;
    localparam int CHUNK  = 4;
    localparam int NCHUNK = WIDTH / CHUNK;
`ifdef CHUNKED_ADDER_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] dbg_state;
    int         cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    chunked_adder_if #(.WIDTH(WIDTH)) bus ();

    chunked_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int                checks = 0;
    int                errors = 0;
    logic [WIDTH+1:0]  exp_q[$];   // {cout, ovf, sum}

    // Reference: full-precision integer result, then reduce.
    function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic cin, input logic sub);
        int   r;
        int   rs;
        logic s;
        logic c;
        logic o;
        s = sub & SUB_EN;
        if (s) begin
            r  = int'(a) - int'(b) - int'(cin);
            rs = int'($signed(a)) - int'($signed(b)) - int'(cin);
            c  = (r >= 0);
        end else begin
            r  = int'(a) + int'(b) + int'(cin);
            rs = int'($signed(a)) + int'($signed(b)) + int'(cin);
            c  = (r > 65535);
        end
        o = (rs > 32767) || (rs < -32768);
        return {c, o, r[WIDTH-1:0]};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    // Called just after a negedge. Returns with out_valid seen (or timed out);
    // lat = rising edges from accept edge to out_valid.
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic cin, input logic sub, output int lat);
        int w;
        w = 0;
        while (!bus.in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        bus.sub      = sub;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic release_result();
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.cout, bus.ovf, bus.sum} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL reset_values got rdy=%0b vld=%0b cout=%0b ovf=%0b sum=%h want 1 0 0 0 0000",
                     bus.in_ready, bus.out_valid, bus.cout, bus.ovf, bus.sum);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got rdy=%0b vld=%0b want 1 0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_directed();
        logic [WIDTH-1:0] va[4];
        logic [WIDTH-1:0] vb[4];
        logic             vsub[4];
        logic [WIDTH+1:0] vexp[4];
        logic [WIDTH+1:0] got;
        int               lat;
        va[0] = 16'h1234; vb[0] = 16'h4321; vsub[0] = 1'b0; vexp[0] = {1'b0, 1'b0, 16'h5555};
        va[1] = 16'hFFFF; vb[1] = 16'h0001; vsub[1] = 1'b0; vexp[1] = {1'b1, 1'b0, 16'h0000};
        va[2] = 16'h7FFF; vb[2] = 16'h0001; vsub[2] = 1'b0; vexp[2] = {1'b0, 1'b1, 16'h8000};
        va[3] = 16'h0005; vb[3] = 16'h0007; vsub[3] = 1'b1;
        vexp[3] = SUB_EN ? {1'b0, 1'b0, 16'hFFFE} : {1'b0, 1'b0, 16'h000C};
        for (int i = 0; i < 4; i++) begin
            issue(va[i], vb[i], 1'b0, vsub[i], lat);
            checks++;
            if (lat !== NCHUNK) begin
                errors++;
                $display("FAIL directed%0d_latency got %0d want %0d", i, lat, NCHUNK);
            end
            got = {bus.cout, bus.ovf, bus.sum};
            checks++;
            if (got !== vexp[i]) begin
                errors++;
                $display("FAIL directed%0d_result got cout=%0b ovf=%0b sum=%h want cout=%0b ovf=%0b sum=%h",
                         i, got[17], got[16], got[15:0], vexp[i][17], vexp[i][16], vexp[i][15:0]);
            end
            release_result();
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic             sub;
        logic [WIDTH+1:0] exp;
        logic [WIDTH+1:0] got;
        int               lat;
        for (int i = 0; i < 40; i++) begin
            a   = WIDTH'($urandom_range(0, 65535));
            b   = WIDTH'($urandom_range(0, 65535));
            cin = 1'($urandom_range(0, 1));
            sub = 1'($urandom_range(0, 1));
            if (i % 8 == 0) a = 16'h8000;          // signed-overflow corner
            exp_q.push_back(model(a, b, cin, sub));
            issue(a, b, cin, sub, lat);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            got = {bus.cout, bus.ovf, bus.sum};
            exp = exp_q.pop_front();
            checks++;
            if (lat !== NCHUNK || got !== exp) begin
                errors++;
                $display("FAIL random%0d a=%h b=%h cin=%0b sub=%0b got lat=%0d %h want lat=%0d %h",
                         i, a, b, cin, sub, lat, got, NCHUNK, exp);
            end
            release_result();
        end
    endtask

    task automatic test_backpressure();
        logic [WIDTH+1:0] exp;
        int               lat;
        exp = model(16'hABCD, 16'h1357, 1'b1, 1'b0);
        issue(16'hABCD, 16'h1357, 1'b1, 1'b0, lat);
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.a        = WIDTH'($urandom_range(0, 65535));
            bus.b        = WIDTH'($urandom_range(0, 65535));
            bus.cin      = 1'b1;
            @(negedge clk);
            checks++;
            if ({bus.cout, bus.ovf, bus.sum} !== exp || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
                errors++;
                $display("FAIL hold%0d got %h rdy=%0b vld=%0b want %h rdy=0 vld=1",
                         i, {bus.cout, bus.ovf, bus.sum}, bus.in_ready, bus.out_valid, exp);
            end
        end
        bus.in_valid = 1'b0;
        release_result();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_exit got rdy=%0b vld=%0b want 1 0", bus.in_ready, bus.out_valid);
        end
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_no_capture got rdy=%0b want 1", bus.in_ready);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [WIDTH+1:0] exp;
        logic [WIDTH+1:0] got;
        int               lat;
        bus.in_valid = 1'b1;
        bus.a        = 16'h1234;
        bus.b        = 16'h4321;
        bus.cin      = 1'b0;
        bus.sub      = 1'b0;
        @(posedge clk);              // accept edge
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);              // first chunk written
        @(negedge clk);              // second RUN cycle
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.out_valid, bus.cout, bus.ovf, bus.sum} !== {1'b0, 1'b0, 1'b0, 16'h0000} || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrun_reset got vld=%0b cout=%0b ovf=%0b sum=%h rdy=%0b want 0 0 0 0000 1",
                     bus.out_valid, bus.cout, bus.ovf, bus.sum, bus.in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrun_ready got %0b want 1", bus.in_ready);
        end
        exp = model(16'h0F0F, 16'h00F1, 1'b1, 1'b0);
        issue(16'h0F0F, 16'h00F1, 1'b1, 1'b0, lat);
        got = {bus.cout, bus.ovf, bus.sum};
        checks++;
        if (lat !== NCHUNK || got !== exp) begin
            errors++;
            $display("FAIL midrun_next got lat=%0d %h want lat=%0d %h", lat, got, NCHUNK, exp);
        end
        release_result();
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH+1:0] exp;
        logic [WIDTH+1:0] got;
        int               lat;
        int               t_prev;
        bus.out_ready = 1'b1;
        t_prev = 0;
        for (int i = 0; i < 4; i++) begin
            a = WIDTH'($urandom_range(0, 65535));
            b = WIDTH'($urandom_range(0, 65535));
            exp_q.push_back(model(a, b, 1'b0, 1'b0));
            issue(a, b, 1'b0, 1'b0, lat);
            got = {bus.cout, bus.ovf, bus.sum};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL b2b%0d_result got %h want %h", i, got, exp);
            end
            if (i > 0) begin
                checks++;
                if (cyc - t_prev !== NCHUNK + 2) begin
                    errors++;
                    $display("FAIL b2b%0d_period got %0d want %0d", i, cyc - t_prev, NCHUNK + 2);
                end
            end
            t_prev = cyc;
            @(negedge clk);          // handshake completes on the edge just passed
        end
        bus.out_ready = 1'b0;
    endtask

    // ---------------- main sequence / report ----------------
    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation exceeded time limit");
        $fatal(1);
    end
endmodule
